// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: default bubble instruction and counter sizing.
package core_pkg;

  // addi x0, x0, 0 -- the canonical RISC-V NOP used to fill empty stages
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic int CNT_W(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Handshake, control and status bundle for pipe_reg_chain.
interface pipe_reg_chain_if
  import core_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 1
) ();

  logic                     hold_flag_i;
  logic                     flush_i;
  logic [DW-1:0]            set_data;
  logic                     in_valid_i;
  logic [DW-1:0]            in_data_i;
  logic                     in_ready_o;
  logic                     out_valid_o;
  logic [DW-1:0]            out_data_o;
  logic                     out_ready_i;
  logic [CNT_W(DEPTH)-1:0]  occupancy_o;

  modport master (
    output hold_flag_i, flush_i, set_data, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, occupancy_o
  );

  modport slave (
    input  hold_flag_i, flush_i, set_data, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, occupancy_o
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline register stage: DW data bits plus a valid flag.
module pipe_stage #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          hold,
  input  logic          adv,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  input  logic [DW-1:0] set_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_reg;
  logic [DW-1:0] data_reg;

  // An invalid upstream item lands as a bubble carrying set_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_VAL;
    end else if (flush) begin
      valid_reg <= 1'b0;
      data_reg  <= set_data;
    end else if (!hold && adv) begin
      valid_reg <= up_valid;
      data_reg  <= up_valid ? up_data : set_data;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register chain with valid/ready on both ends, global hold and flush.
module pipe_reg_chain
  import core_pkg::*;
#(
  parameter int            DW      = 32,
  parameter int            DEPTH   = 1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  pipe_reg_chain_if.slave  bus
);

  localparam int OCC_W = CNT_W(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DW-1:0]    d [DEPTH];
  logic [DEPTH:0]   adv;
  logic             stall;
  logic             in_ready;
  logic             out_valid;
  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;

  // Ready ripples from the output back: a stage may move if it is empty or its successor moves
  always_comb begin
    adv        = '0;
    adv[DEPTH] = bus.out_ready_i;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = ~v[i] | adv[i+1];
    end
  end

  assign stall     = bus.hold_flag_i | bus.flush_i;
  assign in_ready  = adv[0] & ~stall & ~rst;
  assign out_valid = v[DEPTH-1] & ~stall & ~rst;
  assign in_fire   = bus.in_valid_i & in_ready;
  assign out_fire  = out_valid & bus.out_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic          up_valid;
      logic [DW-1:0] up_data;

      if (gi == 0) begin : g_head
        assign up_valid = in_fire;
        assign up_data  = bus.in_data_i;
      end else begin : g_body
        assign up_valid = v[gi-1];
        assign up_data  = d[gi-1];
      end

      pipe_stage #(
        .DW      (DW),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush_i),
        .hold     (bus.hold_flag_i),
        .adv      (adv[gi]),
        .up_valid (up_valid),
        .up_data  (up_data),
        .set_data (bus.set_data),
        .valid    (v[gi]),
        .data     (d[gi])
      );
    end
  endgenerate

  always_comb begin
    occ_next = occ_reg + OCC_W'(in_fire) - OCC_W'(out_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= '0;
    end else if (bus.flush_i) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = d[DEPTH-1];
  assign bus.occupancy_o = occ_reg;

endmodule
